// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the MIPS datapath.
// master: controller side (samples opcode/mem_ready, drives the strobes).
// slave:  datapath side.
interface mips_multicycle_ctrl_if;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  pc_source;
   logic        illegal_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state, instr_count
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (Moore) with retired-instruction counter.
// Optional feature: define MIPS_JUMP_EN to enable the j instruction (JUMP state).
module mips_multicycle_ctrl (
   input logic                    clk,
   input logic                    reset,
   mips_multicycle_ctrl_if.master bus
);

   localparam logic [3:0] StFetch  = 4'd0;
   localparam logic [3:0] StDecode = 4'd1;
   localparam logic [3:0] StMemAdr = 4'd2;
   localparam logic [3:0] StMemRd  = 4'd3;
   localparam logic [3:0] StMemWb  = 4'd4;
   localparam logic [3:0] StMemWr  = 4'd5;
   localparam logic [3:0] StExec   = 4'd6;
   localparam logic [3:0] StAluWb  = 4'd7;
   localparam logic [3:0] StBranch = 4'd8;
   localparam logic [3:0] StAddiEx = 4'd9;
   localparam logic [3:0] StAddiWb = 4'd10;
`ifdef MIPS_JUMP_EN
   localparam logic [3:0] StJump   = 4'd11;
   localparam logic [5:0] OpJ      = 6'b000010;
`endif
   localparam logic [3:0] StIdle   = 4'd15;

   localparam logic [5:0] OpRType  = 6'b000000;
   localparam logic [5:0] OpLw     = 6'b100011;
   localparam logic [5:0] OpSw     = 6'b101011;
   localparam logic [5:0] OpBeq    = 6'b000100;
   localparam logic [5:0] OpAddi   = 6'b001000;

   logic [3:0]  state_q, state_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        retire;
   logic        illegal;

   // Next-state decode; retire flags the transitions that complete an instruction.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      illegal = 1'b0;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (bus.mem_ready) state_d = StDecode;
         StDecode: begin
            case (bus.opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRType:    state_d = StExec;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiEx;
`ifdef MIPS_JUMP_EN
               OpJ:        state_d = StJump;
`endif
               default: begin
                  state_d = StFetch;
                  illegal = 1'b1;
               end
            endcase
         end
         StMemAdr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
         StMemRd:  if (bus.mem_ready) state_d = StMemWb;
         StMemWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StMemWr: begin
            if (bus.mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StExec:   state_d = StAluWb;
         StAluWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StAddiEx: state_d = StAddiWb;
         StAddiWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
`ifdef MIPS_JUMP_EN
         StJump: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
`endif
         // Unused codes recover through IDLE.
         default:  state_d = StIdle;
      endcase
   end

   // Counter wraps naturally at 32 bits.
   always_comb begin
      instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
   end

   // State and counter registers; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Moore output decode; only FETCH looks at mem_ready (IR/PC load on completion).
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      bus.illegal_op    = 1'b0;
      case (state_q)
         StFetch: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         StDecode: begin
            bus.alu_src_b  = 2'b11;
            bus.illegal_op = illegal;
         end
         StMemAdr, StAddiEx: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         StMemRd: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         StMemWb: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         StExec: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         StAluWb: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         StBranch: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_source     = 2'b01;
            bus.pc_write_cond = 1'b1;
         end
         StAddiWb: bus.reg_write = 1'b1;
`ifdef MIPS_JUMP_EN
         StJump: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
`endif
         default: ;
      endcase
   end

   assign bus.state       = state_q;
   assign bus.instr_count = instr_count_q;

endmodule
